mips_boot_sequencer: RTL

Boot and run controller for the single-cycle MIPS core. It sits between a 32-bit word stream (bench or debug link) and the core's memories. On `start` it holds the core in reset, streams a program into instruction memory and initial operands into data memory, then releases the core. It stops the run on a self-loop halt or when a cycle budget expires, and reports completion and cycle count.

---
 rtl/mips_boot_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mips_boot_sequencer.sv
// mips_boot_sequencer: streams a program into IM and operands into DM, then runs the core until halt or budget
module mips_boot_sequencer #(
  parameter int IM_DEPTH = 128,
  parameter int DM_DEPTH = 512,
  localparam int IAW = $clog2(IM_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [7:0]     im_words_i,
  input  logic [9:0]     dm_words_i,
  input  logic [31:0]    run_cycles_i,
  input  logic           s_valid_i,
  input  logic [31:0]    s_data_i,
  output logic           s_ready_o,
  output logic           im_we_o,
  output logic [IAW-1:0] im_addr_o,
  output logic [31:0]    im_d_o,
  output logic           dm_sel_o,
  output logic           ld_dm_we_o,
  output logic [15:0]    ld_dm_address_o,
  output logic [31:0]    ld_dm_d_o,
  output logic           cpu_rst_n_o,
  input  logic [31:0]    cpu_pc_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           timeout_o,
  output logic [31:0]    cycle_count_o
);
  typedef enum logic [2:0] {IDLE, LOAD_IM, LOAD_DM, RELEASE, RUN, DONE} state_t;
  state_t state_q;
  logic s_ready_q, im_we_q, dm_sel_q, ld_dm_we_q, cpu_rst_n_q, timeout_q;
  logic [IAW-1:0] im_addr_q;
  logic [15:0] ld_dm_address_q;
  logic [31:0] im_d_q, ld_dm_d_q, budget_q, prev_pc_q, cycle_count_q;
  logic [7:0] im_n_q, im_n;
  logic [9:0] dm_n_q, dm_n, k_q;
  logic xfer, im_last, dm_last, halt;
  logic [31:0] cc_inc;
  assign im_n = (im_words_i > 8'(IM_DEPTH)) ? 8'(IM_DEPTH) : im_words_i;
  assign dm_n = (dm_words_i > 10'(DM_DEPTH)) ? 10'(DM_DEPTH) : dm_words_i;
  assign xfer = s_valid_i & s_ready_q;
  assign im_last = k_q == 10'(im_n_q) - 10'd1;
  assign dm_last = k_q == dm_n_q - 10'd1;
  assign cc_inc = cycle_count_q + 32'd1;
  // cycle_count is still 0 in the first RUN cycle, so it doubles as the "have a previous PC" flag
  assign halt = (cycle_count_q != 32'd0) && (cpu_pc_i == prev_pc_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_ready_q <= 1'b0;
      im_we_q <= 1'b0;
      dm_sel_q <= 1'b0;
      ld_dm_we_q <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      timeout_q <= 1'b0;
      im_addr_q <= '0;
      ld_dm_address_q <= '0;
      im_d_q <= '0;
      ld_dm_d_q <= '0;
      budget_q <= '0;
      prev_pc_q <= '0;
      cycle_count_q <= '0;
      im_n_q <= '0;
      dm_n_q <= '0;
      k_q <= '0;
    end else begin
      im_we_q <= 1'b0;
      ld_dm_we_q <= 1'b0;
      case (state_q)
        IDLE, DONE: if (start_i) begin
          im_n_q <= im_n;
          dm_n_q <= dm_n;
          budget_q <= run_cycles_i;
          cycle_count_q <= '0;
          timeout_q <= 1'b0;
          k_q <= '0;
          im_addr_q <= '0;
          ld_dm_address_q <= '0;
          state_q <= (im_n != 8'd0) ? LOAD_IM : (dm_n != 10'd0) ? LOAD_DM : RELEASE;
          s_ready_q <= (im_n != 8'd0) || (dm_n != 10'd0);
          dm_sel_q <= (im_n == 8'd0) && (dm_n != 10'd0);
        end
        LOAD_IM: if (xfer) begin
          im_we_q <= 1'b1;
          im_addr_q <= k_q[IAW-1:0];
          im_d_q <= s_data_i;
          k_q <= im_last ? '0 : k_q + 10'd1;
          if (im_last) begin
            s_ready_q <= 1'b0;
            state_q <= (dm_n_q != 10'd0) ? LOAD_DM : RELEASE;
            dm_sel_q <= dm_n_q != 10'd0;
          end
        end
        LOAD_DM: begin
          // re-raises ready after the one-cycle gap that follows the IM phase
          s_ready_q <= !(xfer && dm_last);
          if (xfer) begin
            ld_dm_we_q <= 1'b1;
            ld_dm_address_q <= 16'(k_q);
            ld_dm_d_q <= s_data_i;
            k_q <= dm_last ? '0 : k_q + 10'd1;
            if (dm_last) state_q <= RELEASE;
          end
        end
        RELEASE: begin
          dm_sel_q <= 1'b0;
          k_q <= k_q[0] ? '0 : 10'd1;
          if (k_q[0]) begin
            state_q <= RUN;
            cpu_rst_n_q <= 1'b1;
          end
        end
        RUN: begin
          cycle_count_q <= cc_inc;
          prev_pc_q <= cpu_pc_i;
          if (halt || (budget_q != 32'd0 && cc_inc == budget_q)) begin
            state_q <= DONE;
            cpu_rst_n_q <= 1'b0;
            timeout_q <= !halt;
          end
        end
        default: ;
      endcase
    end
  end
  assign s_ready_o = s_ready_q;
  assign im_we_o = im_we_q;
  assign im_addr_o = im_addr_q;
  assign im_d_o = im_d_q;
  assign dm_sel_o = dm_sel_q;
  assign ld_dm_we_o = ld_dm_we_q;
  assign ld_dm_address_o = ld_dm_address_q;
  assign ld_dm_d_o = ld_dm_d_q;
  assign cpu_rst_n_o = cpu_rst_n_q;
  assign busy_o = (state_q != IDLE) && (state_q != DONE);
  assign done_o = state_q == DONE;
  assign timeout_o = timeout_q;
  assign cycle_count_o = cycle_count_q;
endmodule
